vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL declare these parameters, one per line (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync pulse width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vsync pulse width in lines.
- V_BP, 33, vertical back porch in lines.
- H_POL, 1'b0, asserted level of hsync.
- V_POL, 1'b0, asserted level of vsync.
- CW, 10, counter and coordinate width.

REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk, input, 1, clock.
- rst, input, 1, reset: synchronous, active-high.
- en, input, 1, pixel-clock enable; all timing advances only on clk edges with en=1.
- hsync, output, 1, horizontal sync.
- vsync, output, 1, vertical sync.
- de, output, 1, display enable (active video).
- x, output, CW, pixel column during de, else 0.
- y, output, CW, pixel row during de, else 0.
- line_start, output, 1, one-clk pulse at pixel 0 of every line.
- frame_start, output, 1, one-clk pulse at pixel 0, line 0.
- vblank, output, 1, high while the line counter is at or above V_ACTIVE.

Function
REQ-003 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP, and V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-004 H_TOTAL and V_TOTAL SHALL each be at most 2**CW; violation SHALL be flagged at elaboration (simulation $error).
REQ-005 Internal hcnt SHALL increment by 1 on each enabled edge and wrap from H_TOTAL-1 to 0.
REQ-006 Internal vcnt SHALL increment only on an enabled edge where hcnt wraps, and SHALL wrap from V_TOTAL-1 to 0.
REQ-007 All outputs SHALL be registered decodes of the pre-edge (hcnt,vcnt), updated on the same enabled edge that advances the counters; latency is one enabled edge.
REQ-008 hsync SHALL equal H_POL when hcnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], else ~H_POL.
REQ-009 vsync SHALL equal V_POL when vcnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], else ~V_POL, independent of hcnt.
REQ-010 de SHALL be (hcnt<H_ACTIVE) AND (vcnt<V_ACTIVE).
REQ-011 x and y SHALL equal hcnt and vcnt when de=1, and 0 otherwise.
REQ-012 vblank SHALL be (vcnt>=V_ACTIVE).
REQ-013 line_start SHALL be 1 when hcnt==0, and frame_start SHALL be 1 when hcnt==0 AND vcnt==0.
REQ-014 line_start and frame_start SHALL be high for exactly one clk; any clk edge with en=0 SHALL clear them.
REQ-015 On edges with en=0, counters and all level outputs (hsync, vsync, de, x, y, vblank) SHALL hold their values.
REQ-016 rst SHALL take priority over en.

Reset
REQ-017 On a clk edge with rst=1, the block SHALL set: hcnt=0, vcnt=0, hsync=~H_POL, vsync=~V_POL, de=0, x=0, y=0, vblank=0, line_start=0, frame_start=0.
REQ-018 Asserting rst mid-frame SHALL abandon the frame; the first enabled edge after release SHALL produce line_start=1, frame_start=1, de=1, x=0, y=0.

Verification
REQ-019 The bench SHALL cover these directed scenarios, all with default parameters unless stated:
- rst, then en=1 held: after edge 1, frame_start=1, de=1, x=0; after edge 640, x=639; after edge 641, de=0.
- Same run: hsync=0 after edges 657..752; hsync=1 after edge 753; consecutive line_start pulses exactly 800 edges apart.
- Full frame: vsync=0 for lines 490-491 (1600 edges); vblank=1 for lines 480-524; frame_start period 420000 enabled edges.
- en toggling 1/0 every clk: timing identical in enabled-edge count to the continuous run; pulses are one clk wide; outputs hold on en=0 edges.
- rst asserted at hcnt=300, vcnt=200: all outputs take their reset values; on release, frame restarts at (0,0).
- H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1, H_POL=1, V_POL=1, CW=4: line length 8 edges, hsync=1 at hcnt 5-6, frame length 40 edges, vsync=1 on line 3.

Source files
------------

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vga_timing_gen                                                   |
// | Raster counters plus registered sync/blank/coordinate decodes.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0,
  parameter int   CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // One extra bit so boundary constants equal to 2**CW still compare correctly.
  localparam logic [CW:0] c_H_ACT  = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] c_HS_BEG = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] c_HS_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] c_H_LAST = (CW+1)'(c_H_TOTAL - 1);
  localparam logic [CW:0] c_V_ACT  = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] c_VS_BEG = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] c_VS_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW:0] c_V_LAST = (CW+1)'(c_V_TOTAL - 1);

  if (c_H_TOTAL > 2**CW) begin : g_h_total_chk
    $error("vga_timing_gen: H_TOTAL exceeds 2**CW");
  end

  if (c_V_TOTAL > 2**CW) begin : g_v_total_chk
    $error("vga_timing_gen: V_TOTAL exceeds 2**CW");
  end

  logic [CW-1:0] r_hcnt;
  logic [CW-1:0] r_vcnt;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_de;
  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic          r_line_start;
  logic          r_frame_start;
  logic          r_vblank;

  logic [CW:0]   w_hext;
  logic [CW:0]   w_vext;
  logic          w_h_wrap;
  logic          w_v_wrap;
  logic [CW-1:0] w_hcnt_nxt;
  logic [CW-1:0] w_vcnt_nxt;
  logic          w_h_vis;
  logic          w_v_vis;
  logic          w_de;
  logic          w_hs_act;
  logic          w_vs_act;
  logic          w_h_zero;
  logic          w_v_zero;

  assign w_hext   = {1'b0, r_hcnt};
  assign w_vext   = {1'b0, r_vcnt};
  assign w_h_wrap = (w_hext == c_H_LAST);
  assign w_v_wrap = (w_vext == c_V_LAST);

  always_comb begin
    w_hcnt_nxt = r_hcnt + CW'(1);
    w_vcnt_nxt = r_vcnt;
    if (w_h_wrap) begin
      w_hcnt_nxt = '0;
      w_vcnt_nxt = w_v_wrap ? '0 : r_vcnt + CW'(1);
    end
  end

  assign w_h_vis  = (w_hext < c_H_ACT);
  assign w_v_vis  = (w_vext < c_V_ACT);
  assign w_de     = w_h_vis & w_v_vis;
  assign w_hs_act = (w_hext >= c_HS_BEG) && (w_hext < c_HS_END);
  assign w_vs_act = (w_vext >= c_VS_BEG) && (w_vext < c_VS_END);
  assign w_h_zero = (r_hcnt == '0);
  assign w_v_zero = (r_vcnt == '0);

  // Outputs decode the counter values seen before the edge, so they lag by one enabled edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hcnt        <= '0;
      r_vcnt        <= '0;
      r_hsync       <= ~H_POL;
      r_vsync       <= ~V_POL;
      r_de          <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_vblank      <= 1'b0;
    end else if (en) begin
      r_hcnt        <= w_hcnt_nxt;
      r_vcnt        <= w_vcnt_nxt;
      r_hsync       <= w_hs_act ? H_POL : ~H_POL;
      r_vsync       <= w_vs_act ? V_POL : ~V_POL;
      r_de          <= w_de;
      r_x           <= w_de ? r_hcnt : '0;
      r_y           <= w_de ? r_vcnt : '0;
      r_line_start  <= w_h_zero;
      r_frame_start <= w_h_zero & w_v_zero;
      r_vblank      <= ~w_v_vis;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign x           = r_x;
  assign y           = r_y;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign vblank      = r_vblank;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_vga_timing_gen                                                |
// | Three parameter sets driven in lockstep; table + scoreboard.     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_vga_timing_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
    logic       ls;
    logic       fs;
    logic       vb;
  } out_t;

  typedef struct {
    string name;
    int    inst;
    int    edge_n;
    out_t  exp;
  } vec_t;

  localparam int NI = 3;

  // Instance 0: defaults. 1: short lines, default vertical. 2: tiny raster.
  int HA [NI] = '{640, 24, 4};
  int HF [NI] = '{16, 4, 1};
  int HS [NI] = '{96, 8, 2};
  int HB [NI] = '{48, 4, 1};
  int VA [NI] = '{480, 480, 2};
  int VF [NI] = '{10, 10, 1};
  int VS [NI] = '{2, 2, 1};
  int VB [NI] = '{33, 33, 1};
  bit HP [NI] = '{1'b0, 1'b0, 1'b1};
  bit VP [NI] = '{1'b0, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  logic       a_hs, a_vs, a_de, a_ls, a_fs, a_vb;
  logic [9:0] a_x, a_y;
  logic       b_hs, b_vs, b_de, b_ls, b_fs, b_vb;
  logic [9:0] b_x, b_y;
  logic       c_hs, c_vs, c_de, c_ls, c_fs, c_vb;
  logic [3:0] c_x, c_y;

  vga_timing_gen u_dut_a (
    .clk(clk), .rst(rst), .en(en), .hsync(a_hs), .vsync(a_vs), .de(a_de),
    .x(a_x), .y(a_y), .line_start(a_ls), .frame_start(a_fs), .vblank(a_vb)
  );

  vga_timing_gen #(
    .H_ACTIVE(24), .H_FP(4), .H_SYNC(8), .H_BP(4)
  ) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .hsync(b_hs), .vsync(b_vs), .de(b_de),
    .x(b_x), .y(b_y), .line_start(b_ls), .frame_start(b_fs), .vblank(b_vb)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .CW(4)
  ) u_dut_c (
    .clk(clk), .rst(rst), .en(en), .hsync(c_hs), .vsync(c_vs), .de(c_de),
    .x(c_x), .y(c_y), .line_start(c_ls), .frame_start(c_fs), .vblank(c_vb)
  );

  out_t act [NI];
  assign act[0] = {a_hs, a_vs, a_de, a_x, a_y, a_ls, a_fs, a_vb};
  assign act[1] = {b_hs, b_vs, b_de, b_x, b_y, b_ls, b_fs, b_vb};
  assign act[2] = {c_hs, c_vs, c_de, 6'd0, c_x, 6'd0, c_y, c_ls, c_fs, c_vb};

  initial forever #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  int   mh [NI];
  int   mv [NI];
  out_t mprev [NI];
  out_t sbq [$];
  int   n_en = 0;

  int a_ls_prev, a_ls_n, a_ls_bad, a_ls_run, a_ls_maxw;
  int b_fs_prev, b_fs_per, b_vs_run, b_vs_low;

  function automatic int htot(int i);
    return HA[i] + HF[i] + HS[i] + HB[i];
  endfunction

  function automatic int vtot(int i);
    return VA[i] + VF[i] + VS[i] + VB[i];
  endfunction

  function automatic out_t decode(int i, int h, int v);
    out_t o;
    o.hs = (h >= HA[i] + HF[i] && h < HA[i] + HF[i] + HS[i]) ? HP[i] : ~HP[i];
    o.vs = (v >= VA[i] + VF[i] && v < VA[i] + VF[i] + VS[i]) ? VP[i] : ~VP[i];
    o.de = (h < HA[i]) && (v < VA[i]);
    o.x  = o.de ? 10'(h) : 10'd0;
    o.y  = o.de ? 10'(v) : 10'd0;
    o.ls = (h == 0);
    o.fs = (h == 0) && (v == 0);
    o.vb = (v >= VA[i]);
    return o;
  endfunction

  function automatic out_t rst_val(int i);
    out_t o;
    o    = '0;
    o.hs = ~HP[i];
    o.vs = ~VP[i];
    return o;
  endfunction

  function automatic out_t start_val(int i);
    out_t o;
    o    = rst_val(i);
    o.de = 1'b1;
    o.ls = 1'b1;
    o.fs = 1'b1;
    return o;
  endfunction

  function automatic vec_t mk(string nm, int inst, int e, logic hs, logic vs, logic de,
                              int xv, int yv, logic ls, logic fs, logic vb);
    vec_t t;
    t.name   = nm;
    t.inst   = inst;
    t.edge_n = e;
    t.exp    = {hs, vs, de, 10'(xv), 10'(yv), ls, fs, vb};
    return t;
  endfunction

  task automatic chk(input string nm, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at n_en=%0d got=%h exp=%h", nm, n_en, got, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic meas_clear();
    a_ls_prev = -1; a_ls_n = 0; a_ls_bad = 0; a_ls_run = 0; a_ls_maxw = 0;
    b_fs_prev = -1; b_fs_per = 0; b_vs_run = 0; b_vs_low = 0;
  endtask

  task automatic step(input logic r, input logic e);
    rst = r;
    en  = e;
    for (int i = 0; i < NI; i++) begin
      out_t o;
      if (r) begin
        o = rst_val(i);
        mh[i] = 0;
        mv[i] = 0;
      end else if (e) begin
        o = decode(i, mh[i], mv[i]);
        mh[i]++;
        if (mh[i] == htot(i)) begin
          mh[i] = 0;
          mv[i]++;
          if (mv[i] == vtot(i)) mv[i] = 0;
        end
      end else begin
        o    = mprev[i];
        o.ls = 1'b0;
        o.fs = 1'b0;
      end
      mprev[i] = o;
      sbq.push_back(o);
    end
    if (r) n_en = 0;
    else if (e) n_en++;
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      out_t x_exp;
      x_exp = sbq.pop_front();
      chk($sformatf("sb_inst%0d", i), act[i], x_exp);
    end
    if (act[0].ls) begin
      a_ls_run++;
      if (a_ls_run > a_ls_maxw) a_ls_maxw = a_ls_run;
      if (a_ls_prev >= 0) begin
        a_ls_n++;
        if (n_en - a_ls_prev != 800) a_ls_bad++;
      end
      a_ls_prev = n_en;
    end else begin
      a_ls_run = 0;
    end
    if (act[1].fs) begin
      if (b_fs_prev >= 0) b_fs_per = n_en - b_fs_prev;
      b_fs_prev = n_en;
    end
    if (!act[1].vs) b_vs_run++;
    else if (b_vs_run > 0) begin
      b_vs_low = b_vs_run;
      b_vs_run = 0;
    end
  endtask

  vec_t tbl [$];

  initial begin
    out_t saved;
    int   guard;

    tbl.push_back(mk("c_e1",     2, 1,     0,0,1,  0,0,1,1,0));
    tbl.push_back(mk("a_e1",     0, 1,     1,1,1,  0,0,1,1,0));
    tbl.push_back(mk("b_e1",     1, 1,     1,1,1,  0,0,1,1,0));
    tbl.push_back(mk("c_e4",     2, 4,     0,0,1,  3,0,0,0,0));
    tbl.push_back(mk("c_e5",     2, 5,     0,0,0,  0,0,0,0,0));
    tbl.push_back(mk("c_e6",     2, 6,     1,0,0,  0,0,0,0,0));
    tbl.push_back(mk("c_e7",     2, 7,     1,0,0,  0,0,0,0,0));
    tbl.push_back(mk("c_e8",     2, 8,     0,0,0,  0,0,0,0,0));
    tbl.push_back(mk("c_e9",     2, 9,     0,0,1,  0,1,1,0,0));
    tbl.push_back(mk("c_e17",    2, 17,    0,0,0,  0,0,1,0,1));
    tbl.push_back(mk("c_e25",    2, 25,    0,1,0,  0,0,1,0,1));
    tbl.push_back(mk("b_e25",    1, 25,    1,1,0,  0,0,0,0,0));
    tbl.push_back(mk("b_e29",    1, 29,    0,1,0,  0,0,0,0,0));
    tbl.push_back(mk("c_e33",    2, 33,    0,0,0,  0,0,1,0,1));
    tbl.push_back(mk("b_e36",    1, 36,    0,1,0,  0,0,0,0,0));
    tbl.push_back(mk("b_e37",    1, 37,    1,1,0,  0,0,0,0,0));
    tbl.push_back(mk("c_e40",    2, 40,    0,0,0,  0,0,0,0,1));
    tbl.push_back(mk("c_e41",    2, 41,    0,0,1,  0,0,1,1,0));
    tbl.push_back(mk("b_e41",    1, 41,    1,1,1,  0,1,1,0,0));
    tbl.push_back(mk("a_e640",   0, 640,   1,1,1,639,0,0,0,0));
    tbl.push_back(mk("a_e641",   0, 641,   1,1,0,  0,0,0,0,0));
    tbl.push_back(mk("a_e656",   0, 656,   1,1,0,  0,0,0,0,0));
    tbl.push_back(mk("a_e657",   0, 657,   0,1,0,  0,0,0,0,0));
    tbl.push_back(mk("a_e752",   0, 752,   0,1,0,  0,0,0,0,0));
    tbl.push_back(mk("a_e753",   0, 753,   1,1,0,  0,0,0,0,0));
    tbl.push_back(mk("a_e800",   0, 800,   1,1,0,  0,0,0,0,0));
    tbl.push_back(mk("a_e801",   0, 801,   1,1,1,  0,1,1,0,0));
    tbl.push_back(mk("b_e19200", 1, 19200, 1,1,0,  0,0,0,0,0));
    tbl.push_back(mk("b_e19201", 1, 19201, 1,1,0,  0,0,1,0,1));
    tbl.push_back(mk("b_e19600", 1, 19600, 1,1,0,  0,0,0,0,1));
    tbl.push_back(mk("b_e19601", 1, 19601, 1,0,0,  0,0,1,0,1));
    tbl.push_back(mk("b_e19680", 1, 19680, 1,0,0,  0,0,0,0,1));
    tbl.push_back(mk("b_e19681", 1, 19681, 1,1,0,  0,0,1,0,1));
    tbl.push_back(mk("b_e21000", 1, 21000, 1,1,0,  0,0,0,0,1));
    tbl.push_back(mk("b_e21001", 1, 21001, 1,1,1,  0,0,1,1,0));

    // Reset state
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    for (int i = 0; i < NI; i++) chk($sformatf("reset_inst%0d", i), act[i], rst_val(i));

    // Continuous run, directed vectors
    meas_clear();
    for (int k = 0; k < tbl.size(); k++) begin
      while (n_en < tbl[k].edge_n) step(1'b0, 1'b1);
      chk(tbl[k].name, act[tbl[k].inst], tbl[k].exp);
    end
    chk_int("a_ls_period_bad", a_ls_bad, 0);
    chk_int("a_ls_periods_seen", (a_ls_n >= 20) ? 1 : 0, 1);
    chk_int("a_ls_width", a_ls_maxw, 1);
    chk_int("b_fs_period", b_fs_per, 21000);
    chk_int("b_vsync_low_len", b_vs_low, 80);

    // Mid-frame reset on instance 1 at (30,200), with en held high
    guard = 0;
    while (!(mh[1] == 30 && mv[1] == 200) && guard < 30000) begin
      step(1'b0, 1'b1);
      guard++;
    end
    chk_int("reach_b_30_200", (guard < 30000) ? 1 : 0, 1);
    step(1'b1, 1'b1);
    for (int i = 0; i < NI; i++) chk($sformatf("midrst_inst%0d", i), act[i], rst_val(i));
    step(1'b0, 1'b1);
    for (int i = 0; i < NI; i++) chk($sformatf("restart_inst%0d", i), act[i], start_val(i));

    // en toggling every clk
    meas_clear();
    a_ls_prev = 1;
    for (int k = 0; k < 1700; k++) begin
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      if (k == 100) begin
        saved = act[0];
        step(1'b0, 1'b0);
        saved.ls = 1'b0;
        saved.fs = 1'b0;
        chk("hold_on_en0", act[0], saved);
      end
    end
    chk_int("tog_ls_period_bad", a_ls_bad, 0);
    chk_int("tog_ls_periods_seen", (a_ls_n >= 2) ? 1 : 0, 1);
    chk_int("tog_ls_width", a_ls_maxw, 1);

    // Reset instance 0 at hcnt=300 with en low; rst must still win
    guard = 0;
    while (mh[0] != 300 && guard < 2000) begin
      step(1'b0, 1'b1);
      guard++;
    end
    chk_int("reach_a_h300", (guard < 2000) ? 1 : 0, 1);
    step(1'b1, 1'b0);
    for (int i = 0; i < NI; i++) chk($sformatf("h300rst_inst%0d", i), act[i], rst_val(i));
    step(1'b0, 1'b0);
    chk("rst_release_en0_inst0", act[0], rst_val(0));
    step(1'b0, 1'b1);
    for (int i = 0; i < NI; i++) chk($sformatf("h300restart_inst%0d", i), act[i], start_val(i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
